// File: rtl/render_map_seq.sv
// render_map_seq: tile-map sequencer.
// Walks a GRID_W x GRID_H tile grid in row-major order. For each tile it reads
// the tile index from the map ROM and hands the tile's pixel-ROM base address
// and screen position to the tile renderer.
//
// Ports
//   map_clk, rstn     clock (rising edge) and asynchronous active-low reset
//   start, cont       begin a pass (IDLE only); continuous mode, latched at start
//   abort             synchronous abort back to IDLE, no done
//   map_base          map base address in ROM, latched at start
//   rom_addr/rom_data map-ROM read port; data valid ROM_LAT cycles after addr
//   tile_start        one-cycle pulse, tile_addr/top/left valid
//   tile_addr         tile pixel base = index << (2*TILE_SHIFT)
//   tile_top/left     tile position in pixels
//   tile_done         renderer finished the current tile
//   busy, done        not IDLE; one-cycle pulse at end of a pass
//   frame_cnt         completed passes (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_WAIT  | map-ROM read in flight; index captured when the timer expires
// S_ISSUE | single cycle, tile_start high
// S_RUN   | renderer busy, waiting for tile_done
module render_map_seq #(
  parameter int ADDR_W     = 19,
  parameter int IDX_W      = 16,
  parameter int GRID_W     = 11,
  parameter int GRID_H     = 11,
  parameter int TILE_SHIFT = 5,
  parameter int COORD_W    = 10,
  parameter int ROM_LAT    = 1,
  parameter int SKIP_ZERO  = 1
) (
  input  logic               map_clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               cont,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  map_base,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_data,
  output logic               tile_start,
  output logic [ADDR_W-1:0]  tile_addr,
  output logic [COORD_W-1:0] tile_top,
  output logic [COORD_W-1:0] tile_left,
  input  logic               tile_done,
  output logic               busy,
  output logic               done,
  output logic [15:0]        frame_cnt
);

  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int LAT_W = $clog2(ROM_LAT + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_W - 1);
  // The ROM output register needs one edge after rom_addr changes, so the
  // timer holds WAIT for ROM_LAT+1 cycles before the index is sampled.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROM_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_base;
  logic               r_cont;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [ADDR_W-1:0]  r_tile_addr;
  logic [COORD_W-1:0] r_tile_top;
  logic [COORD_W-1:0] r_tile_left;
  logic               r_done;
  logic [15:0]        r_frame_cnt;

  logic w_accept;
  logic w_capture;
  logic w_advance;
  logic w_lat_dec;
  logic w_last;
  logic w_zero_idx;
  logic w_tile_start;

  assign w_last     = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_zero_idx = (SKIP_ZERO != 0) && (rom_data == '0);

  // A transparent tile is dropped at index capture: it never reaches ISSUE,
  // so it costs exactly the ROM wait and leaves tile_addr/top/left untouched.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_lat_dec    = 1'b0;
    w_tile_start = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) begin
            w_lat_dec = 1'b1;
          end else if (w_zero_idx) begin
            w_advance = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_tile_start = 1'b1;
          w_state_nxt  = S_RUN;
        end
        S_RUN: begin
          if (tile_done) w_advance = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_advance) w_state_nxt = (w_last && !r_cont) ? S_IDLE : S_WAIT;
    end
  end

  always_ff @(posedge map_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge map_clk or negedge rstn) begin
    if (!rstn) begin
      r_row       <= '0;
      r_col       <= '0;
      r_base      <= '0;
      r_cont      <= 1'b0;
      r_rom_addr  <= '0;
      r_lat_cnt   <= '0;
      r_tile_addr <= '0;
      r_tile_top  <= '0;
      r_tile_left <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_row <= '0;
        r_col <= '0;
      end
      if (w_accept) begin
        r_base     <= map_base;
        r_cont     <= cont;
        r_rom_addr <= map_base;
        r_row      <= '0;
        r_col      <= '0;
        r_lat_cnt  <= LAT_LOAD;
      end
      if (w_lat_dec) r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      if (w_capture) begin
        r_tile_addr <= ADDR_W'(rom_data) << (2 * TILE_SHIFT);
        r_tile_top  <= COORD_W'(r_row) << TILE_SHIFT;
        r_tile_left <= COORD_W'(r_col) << TILE_SHIFT;
      end
      if (w_advance) begin
        r_lat_cnt <= LAT_LOAD;
        if (w_last) begin
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_row       <= '0;
          r_col       <= '0;
          r_rom_addr  <= r_base;
        end else begin
          // Row-major walk: base + row*GRID_W + col always steps by one.
          r_rom_addr <= r_rom_addr + ADDR_W'(1);
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign tile_start = w_tile_start;
  assign tile_addr  = r_tile_addr;
  assign tile_top   = r_tile_top;
  assign tile_left  = r_tile_left;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_render_map_seq.sv
module tb_render_map_seq;
  localparam int ADDR_W  = 19;
  localparam int IDX_W   = 16;
  localparam int COORD_W = 10;

  logic               map_clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0, cont = 1'b0, abort = 1'b0, tile_done = 1'b0;
  logic [ADDR_W-1:0]  map_base = '0;
  logic [ADDR_W-1:0]  rom_addr, tile_addr;
  logic [IDX_W-1:0]   rom_data = '0;
  logic               tile_start, busy, done;
  logic [COORD_W-1:0] tile_top, tile_left;
  logic [15:0]        frame_cnt;

  logic               start3 = 1'b0, cont3 = 1'b0, abort3 = 1'b0, tile_done3 = 1'b0;
  logic [ADDR_W-1:0]  map_base3 = '0;
  logic [ADDR_W-1:0]  rom_addr3, tile_addr3;
  logic [IDX_W-1:0]   rom_data3 = '0, p3a = '0, p3b = '0;
  logic               tile_start3, busy3, done3;
  logic [COORD_W-1:0] tile_top3, tile_left3;
  logic [15:0]        frame_cnt3;

  render_map_seq u_dut (
    .map_clk(map_clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort),
    .map_base(map_base), .rom_addr(rom_addr), .rom_data(rom_data),
    .tile_start(tile_start), .tile_addr(tile_addr), .tile_top(tile_top),
    .tile_left(tile_left), .tile_done(tile_done), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
  );

  render_map_seq #(.GRID_W(2), .GRID_H(2), .ROM_LAT(3)) u_dut3 (
    .map_clk(map_clk), .rstn(rstn), .start(start3), .cont(cont3), .abort(abort3),
    .map_base(map_base3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .tile_start(tile_start3), .tile_addr(tile_addr3), .tile_top(tile_top3),
    .tile_left(tile_left3), .tile_done(tile_done3), .busy(busy3), .done(done3),
    .frame_cnt(frame_cnt3)
  );

  always #5 map_clk = ~map_clk;

  // Map ROM models: mode 0 = index 3 everywhere, mode 1 = index pos at odd
  // positions and 0 at even ones (pos counted from rom_base).
  int                 rom_mode = 0;
  logic [ADDR_W-1:0]  rom_base = '0;

  function automatic logic [IDX_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] pos;
    pos = a - rom_base;
    if (rom_mode == 0) return 16'd3;
    return pos[0] ? IDX_W'(pos) : '0;
  endfunction

  always_ff @(posedge map_clk) begin
    rom_data  <= rom_fn(rom_addr);
    p3a       <= IDX_W'(rom_addr3) + 16'd1;
    p3b       <= p3a;
    rom_data3 <= p3b;
  end

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] left;
    logic [ADDR_W-1:0]  rom;
  } tile_t;

  tile_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, n_tile = 0, n_done = 0, busy_low = 0;
  int last_ts = 0, first_ts = 0, done_gap = 0, exp_gap = 0, rend_cnt = 0;
  bit inject = 1'b0, start_noise = 1'b0;

  task automatic push_pass(input logic [ADDR_W-1:0] base);
    for (int p = 0; p < 121; p++) begin
      int    idx;
      tile_t t;
      idx = (rom_mode == 0) ? 3 : ((p % 2 == 1) ? p : 0);
      if (idx == 0) continue;
      t.addr = ADDR_W'(idx << 10);
      t.top  = COORD_W'((p / 11) * 32);
      t.left = COORD_W'((p % 11) * 32);
      t.rom  = base + ADDR_W'(p);
      exp_q.push_back(t);
    end
  endtask

  task automatic clear_tb();
    exp_q.delete();
    n_tile = 0; n_done = 0; busy_low = 0; rend_cnt = 0; done_gap = 0;
    tile_done = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  // One clock: sample outputs at the falling edge, run the scoreboard and the
  // renderer model (tile_done 4 cycles after tile_start), then set inputs.
  task automatic cycle();
    @(negedge map_clk);
    cyc++;
    if (!busy) busy_low++;
    if (done) begin
      n_done++;
      done_gap = cyc - last_ts;
    end
    if (tile_start) begin
      tile_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tile_extra: unexpected tile_start top=%0d left=%0d", tile_top, tile_left);
      end else begin
        e = exp_q.pop_front();
        if (tile_addr !== e.addr || tile_top !== e.top || tile_left !== e.left || rom_addr !== e.rom) begin
          miscompares++;
          $display("FAIL tile_%0d: got addr=%h top=%0d left=%0d rom=%h, want addr=%h top=%0d left=%0d rom=%h",
                   n_tile, tile_addr, tile_top, tile_left, rom_addr, e.addr, e.top, e.left, e.rom);
        end
      end
      if (exp_gap != 0 && n_tile > 0) begin
        vectors++;
        if (cyc - last_ts !== exp_gap) begin
          miscompares++;
          $display("FAIL tile_gap_%0d: got %0d cycles, want %0d", n_tile, cyc - last_ts, exp_gap);
        end
      end
      if (n_tile == 0) first_ts = cyc;
      n_tile++;
      last_ts = cyc;
    end
    tile_done = 1'b0;
    if (rend_cnt > 0) begin
      rend_cnt--;
      if (rend_cnt == 0) tile_done = 1'b1;
    end else if (inject) begin
      tile_done = 1'b1;
    end
    if (tile_start) rend_cnt = 4;
    start = start_noise && (rend_cnt > 0);
  endtask

  task automatic run_until_done(input int target, input int budget);
    int t;
    t = 0;
    while (n_done < target && t < budget) begin
      cycle();
      t++;
    end
    vectors++;
    if (n_done < target) begin
      miscompares++;
      $display("FAIL timeout_done: got %0d done pulses after %0d cycles, want %0d", n_done, t, target);
    end
  endtask

  task automatic run_until_tiles(input int target, input int budget);
    int t;
    t = 0;
    while (n_tile < target && t < budget) begin
      cycle();
      t++;
    end
    vectors++;
    if (n_tile < target) begin
      miscompares++;
      $display("FAIL timeout_tiles: got %0d tiles after %0d cycles, want %0d", n_tile, t, target);
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] base, input logic c);
    int c0;
    map_base = base;
    cont     = c;
    start    = 1'b1;
    c0 = cyc;
    cycle();
    map_base = '1;
    cont     = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_busy: got busy=%b, want 1", busy);
    end
    first_ts = c0;
  endtask

  task automatic test_reset();
    @(negedge map_clk);
    @(negedge map_clk);
    vectors++;
    if ({tile_start, busy, done, busy3} !== 4'b0 || rom_addr !== '0 || tile_addr !== '0 ||
        tile_top !== '0 || tile_left !== '0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_values: got ts=%b busy=%b done=%b rom=%h addr=%h top=%0d left=%0d fc=%0d, want all 0",
               tile_start, busy, done, rom_addr, tile_addr, tile_top, tile_left, frame_cnt);
    end
    rstn = 1'b1;
    cycle();
    vectors++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b fc=%0d, want 0 0", busy, frame_cnt);
    end
  endtask

  task automatic test_full_pass();
    int c0;
    clear_tb();
    rom_mode = 0; rom_base = 19'h100; exp_gap = 7;
    push_pass(19'h100);
    c0 = cyc;
    kick(19'h100, 1'b0);
    run_until_done(1, 2000);
    vectors++;
    if (first_ts - c0 !== 3) begin
      miscompares++;
      $display("FAIL start_latency: got %0d cycles, want 3", first_ts - c0);
    end
    vectors++;
    if (n_tile !== 121 || exp_q.size() !== 0 || frame_cnt !== 16'd1 || done_gap !== 5) begin
      miscompares++;
      $display("FAIL full_pass: got tiles=%0d left=%0d fc=%0d done_gap=%0d, want 121 0 1 5",
               n_tile, exp_q.size(), frame_cnt, done_gap);
    end
    cycle();
    cycle();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || n_done !== 1) begin
      miscompares++;
      $display("FAIL full_pass_end: got busy=%b done=%b dones=%0d, want 0 0 1", busy, done, n_done);
    end
  endtask

  task automatic test_skip_zero();
    clear_tb();
    rom_mode = 1; rom_base = 19'h100; exp_gap = 9;
    push_pass(19'h100);
    kick(19'h100, 1'b0);
    run_until_done(1, 3000);
    vectors++;
    if (n_tile !== 60 || exp_q.size() !== 0 || frame_cnt !== 16'd2 || done_gap !== 7) begin
      miscompares++;
      $display("FAIL skip_zero: got tiles=%0d left=%0d fc=%0d done_gap=%0d, want 60 0 2 7",
               n_tile, exp_q.size(), frame_cnt, done_gap);
    end
    cycle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL skip_zero_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_cont();
    @(negedge map_clk);
    rstn = 1'b0;
    @(negedge map_clk);
    rstn = 1'b1;
    clear_tb();
    rom_mode = 0; rom_base = 19'h100; exp_gap = 7;
    push_pass(19'h100);
    push_pass(19'h100);
    kick(19'h100, 1'b1);
    busy_low = 0;
    run_until_done(2, 3000);
    vectors++;
    if (n_tile !== 242 || exp_q.size() !== 0 || frame_cnt !== 16'd2 || busy_low !== 0) begin
      miscompares++;
      $display("FAIL cont_pass: got tiles=%0d left=%0d fc=%0d busy_low=%0d, want 242 0 2 0",
               n_tile, exp_q.size(), frame_cnt, busy_low);
    end
    vectors++;
    if (rom_addr !== 19'h100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_wrap: got rom=%h busy=%b, want 100 1", rom_addr, busy);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_abort: got busy=%b fc=%0d done=%b, want 0 2 0", busy, frame_cnt, done);
    end
  endtask

  task automatic test_abort();
    clear_tb();
    rom_mode = 0; rom_base = 19'h100; exp_gap = 7;
    push_pass(19'h100);
    kick(19'h100, 1'b0);
    run_until_tiles(51, 1000);
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    rend_cnt = 0;
    tile_done = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || tile_start !== 1'b0 || frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL abort_run: got busy=%b done=%b ts=%b fc=%0d, want 0 0 0 2", busy, done, tile_start, frame_cnt);
    end
    for (int i = 0; i < 10; i++) cycle();
    vectors++;
    if (n_done !== 0 || n_tile !== 51) begin
      miscompares++;
      $display("FAIL abort_quiet: got dones=%0d tiles=%0d, want 0 51", n_done, n_tile);
    end
    start = 1'b1;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_abort_idle: got busy=%b, want 0", busy);
    end
    clear_tb();
    rom_base = 19'h040;
    push_pass(19'h040);
    kick(19'h040, 1'b0);
    run_until_done(1, 2000);
    vectors++;
    if (n_tile !== 121 || exp_q.size() !== 0 || frame_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL abort_restart: got tiles=%0d left=%0d fc=%0d, want 121 0 3", n_tile, exp_q.size(), frame_cnt);
    end
  endtask

  task automatic test_noise();
    clear_tb();
    rom_mode = 0; rom_base = 19'h100; exp_gap = 7;
    push_pass(19'h100);
    kick(19'h100, 1'b0);
    inject = 1'b1;
    start_noise = 1'b1;
    run_until_done(1, 2000);
    inject = 1'b0;
    start_noise = 1'b0;
    cycle();
    vectors++;
    if (n_tile !== 121 || exp_q.size() !== 0 || frame_cnt !== 16'd4 || n_done !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL noise_pass: got tiles=%0d left=%0d fc=%0d dones=%0d busy=%b, want 121 0 4 1 0",
               n_tile, exp_q.size(), frame_cnt, n_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_tb();
    rom_mode = 0; rom_base = 19'h100; exp_gap = 7;
    push_pass(19'h100);
    kick(19'h100, 1'b0);
    run_until_tiles(30, 1000);
    cycle();
    cycle();
    rstn = 1'b0;
    #1;
    vectors++;
    if ({tile_start, busy, done} !== 3'b0 || rom_addr !== '0 || tile_addr !== '0 ||
        tile_top !== '0 || tile_left !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got ts=%b busy=%b done=%b rom=%h addr=%h top=%0d left=%0d, want all 0",
               tile_start, busy, done, rom_addr, tile_addr, tile_top, tile_left);
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_frame_cnt: got %0d, want 0", frame_cnt);
    end
    @(negedge map_clk);
    rstn = 1'b1;
    clear_tb();
  endtask

  task automatic test_lat3();
    int n;
    map_base3 = 19'h010;
    start3 = 1'b1;
    n = 0;
    @(negedge map_clk);
    start3 = 1'b0;
    map_base3 = '0;
    n = 1;
    while (tile_start3 !== 1'b1 && n < 20) begin
      @(negedge map_clk);
      n++;
    end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL lat3_latency: got %0d cycles, want 5", n);
    end
    vectors++;
    if (tile_addr3 !== 19'h04400 || tile_top3 !== '0 || tile_left3 !== '0 || rom_addr3 !== 19'h010) begin
      miscompares++;
      $display("FAIL lat3_tile: got addr=%h top=%0d left=%0d rom=%h, want 04400 0 0 010",
               tile_addr3, tile_top3, tile_left3, rom_addr3);
    end
    abort3 = 1'b1;
    @(negedge map_clk);
    abort3 = 1'b0;
    vectors++;
    if (busy3 !== 1'b0 || frame_cnt3 !== 16'd0) begin
      miscompares++;
      $display("FAIL lat3_abort: got busy=%b fc=%0d, want 0 0", busy3, frame_cnt3);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_skip_zero();
    test_cont();
    test_abort();
    test_noise();
    test_reset_mid();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
